// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter (start, data LSB first, optional parity, stop)
// Optional transmit FIFO in front of the FSM when UART_TX_FIFO_EN is defined.

`ifdef UART_TX_FIFO_EN
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr_nxt;
  logic [PW-1:0]    rptr_nxt;
  logic [PW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_nxt  = wptr + PW'(do_push);
    rptr_nxt  = rptr + PW'(do_pop);
    count_nxt = wptr_nxt - rptr_nxt;
  end

  // full is registered from the next-state pointers so in_ready never sees in_valid combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      full <= 1'b0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
      full <= (count_nxt == PW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= push_data;
    end
  end

  assign empty    = (wptr == rptr);
  assign pop_data = mem[rptr[AW-1:0]];
endmodule
`endif

module uart_tx_frame #(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic [2:0]       AFTER_DATA = (PARITY != 0) ? S_PARITY : S_STOP;

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_frame: CLK_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, at least 2");
  end

  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_tick;
  logic                 tx_nxt;
  logic                 start_frame;
  logic [DATA_BITS-1:0] load_word;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_data;

  // the FSM pops on the same edge it leaves IDLE
  assign fifo_pop = (state == S_IDLE) && !fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign in_ready    = !fifo_full;
  assign start_frame = fifo_pop;
  assign load_word   = fifo_data;
  assign busy        = (state != S_IDLE) || !fifo_empty;
`else
  assign in_ready    = (state == S_IDLE);
  assign start_frame = in_valid && in_ready;
  assign load_word   = in_data;
  assign busy        = (state != S_IDLE);
`endif

  assign bit_tick = (div_cnt == '0);

  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg[0];
      S_PARITY: tx_nxt = par_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // tx is a flop one cycle behind state; this also yields the idle-high clk between frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      tx <= tx_nxt;
      case (state)
        S_IDLE: begin
          if (start_frame) begin
            state   <= S_START;
            div_cnt <= DIV_LAST;
            bit_idx <= '0;
            shreg   <= load_word;
            par_bit <= (^load_word) ^ PAR_ODD;
          end
        end
        S_START: begin
          if (bit_tick) begin
            state   <= S_DATA;
            div_cnt <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            div_cnt <= DIV_LAST;
            shreg   <= shreg >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= AFTER_DATA;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            state   <= S_STOP;
            div_cnt <= DIV_LAST;
            bit_idx <= '0;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (bit_idx == STOP_LAST) begin
              state   <= S_IDLE;
              div_cnt <= '0;
              bit_idx <= '0;
            end else begin
              div_cnt <= DIV_LAST;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          div_cnt <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame across several parameter sets
module tb_uart_tx_frame;
`ifdef UART_TX_FIFO_EN
  localparam int NI = 5;
`else
  localparam int NI = 4;
`endif
  localparam int CD_T  [5] = '{4, 4, 4, 3, 2};
  localparam int DB_T  [5] = '{8, 8, 8, 5, 8};
  localparam int PAR_T [5] = '{0, 2, 1, 0, 0};
  localparam int SB_T  [5] = '{1, 1, 1, 2, 1};

  logic       clk;
  logic       rst_n;
  logic [8:0] din    [5];
  logic       vld    [5];
  logic       tx_w   [5];
  logic       busy_w [5];
  logic       rdy_w  [5];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] exp_q  [5][$];
  int         starts [5][$];

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[0][7:0]), .in_valid(vld[0]),
    .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[1][7:0]), .in_valid(vld[1]),
    .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .in_data(din[2][7:0]), .in_valid(vld[2]),
    .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx_frame #(.CLK_DIV(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst_n(rst_n), .in_data(din[3][4:0]), .in_valid(vld[3]),
    .in_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));
`ifdef UART_TX_FIFO_EN
  uart_tx_frame #(.CLK_DIV(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_fifo (
    .clk(clk), .rst_n(rst_n), .in_data(din[4][7:0]), .in_valid(vld[4]),
    .in_ready(rdy_w[4]), .tx(tx_w[4]), .busy(busy_w[4]));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return (1 + DB_T[i] + ((PAR_T[i] != 0) ? 1 : 0) + SB_T[i]) * CD_T[i];
  endfunction

  function automatic logic [63:0] exp_frame(input int i, input logic [8:0] w);
    logic [63:0] v;
    logic [8:0]  d;
    logic        p;
    int          b;
    d = w & 9'((1 << DB_T[i]) - 1);
    p = ^d;
    if (PAR_T[i] == 1) p = ~p;
    v = '0;
    for (int c = 0; c < frame_len(i); c++) begin
      b = c / CD_T[i];
      if (b == 0) v[c] = 1'b0;
      else if (b <= DB_T[i]) v[c] = d[b-1];
      else if (PAR_T[i] != 0 && b == DB_T[i] + 1) v[c] = p;
      else v[c] = 1'b1;
    end
    return v;
  endfunction

  // watches one tx line, captures every frame cycle by cycle and scores it against the queue
  task automatic monitor(input int i);
    logic        prev;
    logic [63:0] obs;
    logic [8:0]  w;
    bit          aborted;
    bit          have;
    int          f;
    prev = 1'b1;
    f = frame_len(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev && !tx_w[i]) begin
        starts[i].push_back(cyc);
        have = (exp_q[i].size() != 0);
        check($sformatf("frame_expected_%0d", i), 64'(have), 64'd1);
        w = have ? exp_q[i].pop_front() : 9'd0;
        obs = '0;
        obs[0] = tx_w[i];
        aborted = 1'b0;
        for (int c = 1; c < f; c++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          obs[c] = tx_w[i];
        end
        if (!aborted && have) check($sformatf("frame_bits_%0d_w%0h", i, w), obs, exp_frame(i, w));
        prev = aborted ? 1'b1 : tx_w[i];
      end else begin
        prev = tx_w[i];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge after the accept edge with acc = cyc there
  task automatic send(input int i, input logic [8:0] w, output int acc);
    int n;
    n = 0;
    din[i] = w;
    vld[i] = 1'b1;
    while (!rdy_w[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("send_ready_%0d", i), 64'(rdy_w[i]), 64'd1);
    exp_q[i].push_back(w);
    @(posedge clk);
    #1 vld[i] = 1'b0;
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic busy_len(input int i, output int n);
    n = 0;
    while (busy_w[i] && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int a;
    int a2;
    int n;
    int low;
    int k;
    int blocked;
    int first_pre;
    int drop;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din[i] = '0;
      vld[i] = 1'b0;
    end
    idle(3);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tx_%0d", i), 64'(tx_w[i]), 64'd1);
      check($sformatf("rst_busy_%0d", i), 64'(busy_w[i]), 64'd0);
      check($sformatf("rst_ready_%0d", i), 64'(rdy_w[i]), 64'd1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      automatic int j = i;
      fork
        monitor(j);
      join_none
    end
    idle(3);

    // 8N1, 0x55
    send(0, 9'h55, a);
    check("8n1_busy_after_accept", 64'(busy_w[0]), 64'd1);
    check("8n1_tx_high_at_accept", 64'(tx_w[0]), 64'd1);
    busy_len(0, n);
    check("8n1_busy_len", 64'(n), 64'd40);
    idle(5);
    check("8n1_frame_count", 64'(starts[0].size()), 64'd1);
    check("8n1_start_latency", 64'((starts[0].size() != 0) ? starts[0][0] - a : -1), 64'd1);
    check("8n1_drained", 64'(exp_q[0].size()), 64'd0);
    starts[0].delete();

    // parity even / odd, 0x07
    send(1, 9'h07, a);
    busy_len(1, n);
    check("8e1_busy_len", 64'(n), 64'd44);
    send(2, 9'h07, a);
    busy_len(2, n);
    check("8o1_busy_len", 64'(n), 64'd44);

    // 5N2, CLK_DIV=3, 0x1F
    send(3, 9'h1F, a);
    busy_len(3, n);
    check("5n2_busy_len", 64'(n), 64'd24);
    idle(5);
    for (int i = 1; i < 4; i++) check($sformatf("drained_%0d", i), 64'(exp_q[i].size()), 64'd0);

    // in_valid held through a frame; data changes after accept must not leak in
    din[0] = 9'h3C;
    vld[0] = 1'b1;
    exp_q[0].push_back(9'h3C);
    @(posedge clk);
    #1 din[0] = 9'hC3;
    exp_q[0].push_back(9'hC3);
    @(negedge clk);
    low = 0;
    n = 0;
    while (!rdy_w[0] && n < 500) begin
      low++;
      n++;
      @(negedge clk);
    end
    check("hold_ready_low_len", 64'(low), 64'd40);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    a2 = cyc;
    idle(60);
    check("hold_frame_count", 64'(starts[0].size()), 64'd2);
    if (starts[0].size() == 2) begin
      check("hold_second_latency", 64'(starts[0][1] - a2), 64'd1);
      check("hold_frame_spacing", 64'(starts[0][1] - starts[0][0]), 64'd41);
    end
    check("hold_drained", 64'(exp_q[0].size()), 64'd0);
    starts[0].delete();

`ifdef UART_TX_FIFO_EN
    // FIFO depth 4, in_valid held with 0x01..0x08
    k = 1;
    blocked = -1;
    first_pre = -1;
    n = 0;
    din[4] = 9'd1;
    vld[4] = 1'b1;
    while (k <= 8 && n < 3000) begin
      if (rdy_w[4]) begin
        exp_q[4].push_back(din[4]);
        if (k == 1) first_pre = cyc;
        k++;
      end else if (blocked < 0) begin
        blocked = k - 1;
      end
      @(posedge clk);
      #1;
      if (k > 8) vld[4] = 1'b0;
      else din[4] = 9'(k);
      @(negedge clk);
      n++;
    end
    vld[4] = 1'b0;
    check("fifo_accepts_before_block", 64'(blocked), 64'd5);
    n = 0;
    while (busy_w[4] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    drop = cyc;
    idle(5);
    check("fifo_frame_count", 64'(starts[4].size()), 64'd8);
    if (starts[4].size() == 8) begin
      check("fifo_first_latency", 64'(starts[4][0] - first_pre), 64'd3);
      for (int j = 1; j < 8; j++) check($sformatf("fifo_spacing_%0d", j), 64'(starts[4][j] - starts[4][j-1]), 64'd21);
      check("fifo_busy_end", 64'(drop - starts[4][7]), 64'd19);
    end
    check("fifo_drained", 64'(exp_q[4].size()), 64'd0);
`endif

    // async reset in the middle of data bit 3
    send(0, 9'h00, a);
    idle(18);
    check("mid_bit3_tx_low", 64'(tx_w[0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 64'(tx_w[0]), 64'd1);
    check("async_rst_busy", 64'(busy_w[0]), 64'd0);
    check("async_rst_ready", 64'(rdy_w[0]), 64'd1);
    idle(3);
    rst_n = 1'b1;
    low = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!tx_w[0]) low++;
    end
    check("post_rst_line_idle", 64'(low), 64'd0);
    send(0, 9'hA5, a);
    busy_len(0, n);
    check("post_rst_busy_len", 64'(n), 64'd40);
    idle(5);
    for (int i = 0; i < NI; i++) check($sformatf("final_drained_%0d", i), 64'(exp_q[i].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
